// File: rtl/link_align_ctrl_if.sv
// Bundles the deserializer-side inputs and decoder-side outputs of the link aligner.
// The master modport is the stream source/observer and the slave modport is the aligner.
interface link_align_ctrl_if;
  logic        raw_valid;
  logic [7:0]  raw_word;
  logic        err_clr;
  logic        bitslip;
  logic        locked;
  logic        dec_valid;
  logic [7:0]  dec_word;
  logic        dec_isK;
  logic [15:0] err_count;

  modport master (
    output raw_valid, raw_word, err_clr,
    input  bitslip, locked, dec_valid, dec_word, dec_isK, err_count
  );

  modport slave (
    input  raw_valid, raw_word, err_clr,
    output bitslip, locked, dec_valid, dec_word, dec_isK, err_count
  );
endinterface

// File: rtl/link_align_ctrl.sv
// Word aligner: hunts for the sync symbol with bitslips, verifies a run of legal
// words, then forwards symbols to the decoder while tracking errors.
module link_align_ctrl #(
  parameter int LOCK_COUNT    = 16,
  parameter int UNLOCK_ERRORS = 4,
  parameter int SLIP_WAIT     = 4
) (
  input logic               clk,
  input logic               rst_n,
  link_align_ctrl_if.slave  link
);

  typedef enum logic [1:0] {HUNT, SLIP_HOLD, VERIFY, LOCKED} stateT;

  localparam logic [7:0] SYNC_WORD   = 8'h78;
  localparam logic [7:0] LOCK_TARGET = 8'(LOCK_COUNT);
  localparam logic [3:0] UNLOCK_LIM  = 4'(UNLOCK_ERRORS);
  localparam logic [3:0] SLIP_LAST   = 4'(SLIP_WAIT - 1);

  stateT       state, stateNext;
  logic [7:0]  runCount, runNext;
  logic [3:0]  unlockCount, unlockNext;
  logic [3:0]  slipCount, slipNext;
  logic [7:0]  prevWord;
  logic [15:0] errCount;
  logic        decValid, decIsK;
  logic [7:0]  decWord;
  logic        slipReq, forward, errInc;
  logic        wordLegal, wordSync, wordIsK;
  logic [7:0]  runInc;
  logic [3:0]  unlockInc;

  assign wordLegal = ((link.raw_word[7:6] == 2'b01) || (link.raw_word[7:6] == 2'b10)) &&
                     ($countones(link.raw_word) == 4);
  assign wordSync  = (link.raw_word == SYNC_WORD);
  // 8'h55 is only a control character when it directly follows the sync symbol
  assign wordIsK   = (link.raw_word == 8'h47) || (link.raw_word == 8'h6A) || wordSync ||
                     ((link.raw_word == 8'h55) && (prevWord == SYNC_WORD));
  assign runInc    = runCount + 8'd1;
  assign unlockInc = unlockCount + 4'd1;

  always_comb begin
    stateNext  = state;
    runNext    = runCount;
    unlockNext = unlockCount;
    slipNext   = slipCount;
    slipReq    = 1'b0;
    forward    = 1'b0;
    errInc     = 1'b0;
    case (state)
      HUNT: begin
        if (link.raw_valid) begin
          if (wordSync) begin
            stateNext = VERIFY;
            runNext   = 8'd1;
          end else begin
            stateNext = SLIP_HOLD;
            slipReq   = 1'b1;
            slipNext  = 4'd0;
          end
        end
      end
      SLIP_HOLD: begin
        if (slipCount == SLIP_LAST) begin
          stateNext = HUNT;
        end else begin
          slipNext = slipCount + 4'd1;
        end
      end
      VERIFY: begin
        if (link.raw_valid) begin
          if (!wordLegal) begin
            stateNext = HUNT;
            runNext   = 8'd0;
          end else begin
            runNext = runInc;
            if (runInc == LOCK_TARGET) begin
              stateNext = LOCKED;
              forward   = 1'b1;
            end
          end
        end
      end
      LOCKED: begin
        if (link.raw_valid) begin
          forward = 1'b1;
          // Illegal takes precedence; a sync word can never be illegal anyway
          if (!wordLegal) begin
            errInc = 1'b1;
            if (unlockInc == UNLOCK_LIM) begin
              stateNext  = HUNT;
              runNext    = 8'd0;
              unlockNext = 4'd0;
            end else begin
              unlockNext = unlockInc;
            end
          end else if (wordSync) begin
            unlockNext = 4'd0;
          end
        end
      end
      default: stateNext = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      runCount    <= 8'd0;
      unlockCount <= 4'd0;
      slipCount   <= 4'd0;
      prevWord    <= 8'd0;
    end else begin
      state       <= stateNext;
      runCount    <= runNext;
      unlockCount <= unlockNext;
      slipCount   <= slipNext;
      if (link.raw_valid) begin
        prevWord <= link.raw_word;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errCount <= 16'd0;
      decValid <= 1'b0;
      decWord  <= 8'd0;
      decIsK   <= 1'b0;
    end else begin
      if (link.err_clr) begin
        errCount <= 16'd0;
      end else if (errInc && (errCount != 16'hFFFF)) begin
        errCount <= errCount + 16'd1;
      end
      decValid <= forward;
      if (forward) begin
        decWord <= link.raw_word;
        decIsK  <= wordIsK;
      end
    end
  end

  // The slip request is decoded from HUNT, so reset must mask it directly
  assign link.bitslip   = slipReq & rst_n;
  assign link.locked    = (state == LOCKED);
  assign link.dec_valid = decValid;
  assign link.dec_word  = decWord;
  assign link.dec_isK   = decIsK;
  assign link.err_count = errCount;

endmodule

// File: tb/tb_link_align_ctrl.sv
// Testbench for link_align_ctrl: directed lock/unlock sequences, a vector table
// and a long randomized stream compared against a behavioural model.
module tb_link_align_ctrl;
  localparam int LOCK_COUNT    = 16;
  localparam int UNLOCK_ERRORS = 4;
  localparam int SLIP_WAIT     = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  link_align_ctrl_if bus();

  link_align_ctrl #(
    .LOCK_COUNT(LOCK_COUNT),
    .UNLOCK_ERRORS(UNLOCK_ERRORS),
    .SLIP_WAIT(SLIP_WAIT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .link(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: integer run length, hold countdown and error tallies instead of states
  bit         mLocked;
  int         runLen, holdLeft, badCount, errCnt;
  bit         mDecValid, mDecIsK;
  logic [7:0] mDecWord, mPrev;

  typedef struct {
    bit         valid;
    logic [7:0] word;
    bit         clr;
    bit         expLocked;
    bit         expDecValid;
    bit         expIsK;
    int         expErr;
  } vecT;
  vecT vecs[16];

  function automatic bit isLegal(logic [7:0] w);
    int ones = 0;
    for (int b = 0; b < 8; b++) ones += int'(w[b]);
    return (w[7] != w[6]) && (ones == 4);
  endfunction

  task automatic checkOutput(string name, logic [15:0] actual, logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mLocked = 0; runLen = 0; holdLeft = 0; badCount = 0; errCnt = 0;
    mDecValid = 0; mDecIsK = 0; mDecWord = 8'd0; mPrev = 8'd0;
  endtask

  task automatic modelAdvance(bit v, logic [7:0] w, bit c);
    bit legal = isLegal(w);
    bit sync  = (w == 8'h78);
    bit fwd   = 0;
    if (holdLeft > 0) begin
      holdLeft--;
    end else if (mLocked) begin
      if (v) begin
        fwd = 1;
        if (!legal) begin
          if (errCnt < 65535) errCnt++;
          badCount++;
          if (badCount == UNLOCK_ERRORS) begin
            mLocked = 0; runLen = 0; badCount = 0;
          end
        end else if (sync) begin
          badCount = 0;
        end
      end
    end else if (runLen == 0) begin
      if (v) begin
        if (sync) runLen = 1;
        else holdLeft = SLIP_WAIT;
      end
    end else if (v) begin
      if (!legal) begin
        runLen = 0;
      end else begin
        runLen++;
        if (runLen == LOCK_COUNT) begin
          mLocked = 1; fwd = 1;
        end
      end
    end
    if (c) errCnt = 0;
    if (fwd) begin
      mDecWord = w;
      mDecIsK  = (w == 8'h47) || (w == 8'h6A) || (w == 8'h78) || ((w == 8'h55) && (mPrev == 8'h78));
    end
    mDecValid = fwd;
    if (v) mPrev = w;
  endtask

  // Drives one cycle's inputs in the low phase, checks against the model, then advances it
  task automatic applyStimulus(bit v, logic [7:0] w, bit c);
    bit expSlip;
    @(negedge clk);
    bus.raw_valid = v;
    bus.raw_word  = w;
    bus.err_clr   = c;
    #1;
    expSlip = v && !mLocked && (runLen == 0) && (holdLeft == 0) && (w != 8'h78);
    checkOutput("bitslip", 16'(bus.bitslip), 16'(expSlip));
    checkOutput("locked", 16'(bus.locked), 16'(mLocked));
    checkOutput("dec_valid", 16'(bus.dec_valid), 16'(mDecValid));
    checkOutput("dec_word", 16'(bus.dec_word), 16'(mDecWord));
    checkOutput("dec_isK", 16'(bus.dec_isK), 16'(mDecIsK));
    checkOutput("err_count", bus.err_count, 16'(errCnt));
    modelAdvance(v, w, c);
  endtask

  task automatic doReset();
    bus.raw_valid = 1'b0;
    bus.err_clr   = 1'b0;
    rst_n = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic acquireLock();
    applyStimulus(1'b1, 8'h78, 1'b0);
    for (int k = 1; k < LOCK_COUNT; k++) applyStimulus(1'b1, 8'h59, 1'b0);
    checkOutput("preLockLow", 16'(bus.locked), 16'd0);
    @(posedge clk); #1;
    checkOutput("lockAfter16", 16'(bus.locked), 16'd1);
    checkOutput("lockWordFwd", 16'(bus.dec_valid), 16'd1);
    checkOutput("lockWordVal", 16'(bus.dec_word), 16'h59);
  endtask

  function automatic logic [7:0] pickWord(int errPct);
    logic [7:0] w;
    if (int'($urandom_range(0, 99)) < errPct) begin
      case ($urandom_range(0, 2))
        0: w = 8'hFF;
        1: w = 8'h00;
        default: w = 8'($urandom_range(0, 255));
      endcase
    end else begin
      case ($urandom_range(0, 5))
        0, 1: w = 8'h78;
        2: w = 8'h59;
        3: w = 8'h47;
        4: w = 8'h6A;
        default: w = 8'h55;
      endcase
    end
    return w;
  endfunction

  initial begin
    int pct[5];
    // valid, word, clr, locked, dec_valid, dec_isK, err_count after the edge
    vecs[0]  = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1};
    vecs[1]  = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 2};
    vecs[2]  = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 3};
    vecs[3]  = '{1'b1, 8'h78, 1'b0, 1'b1, 1'b1, 1'b1, 3};
    vecs[4]  = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 4};
    vecs[5]  = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 5};
    vecs[6]  = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 6};
    vecs[7]  = '{1'b1, 8'h78, 1'b0, 1'b1, 1'b1, 1'b1, 6};
    vecs[8]  = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 1'b1, 6};
    vecs[9]  = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 6};
    vecs[10] = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 0};
    vecs[11] = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1};
    vecs[12] = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 2};
    vecs[13] = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 3};
    vecs[14] = '{1'b1, 8'h59, 1'b0, 1'b0, 1'b0, 1'b0, 3};
    vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    pct = '{1, 3, 0, 10, 50};

    bus.raw_valid = 1'b0;
    bus.raw_word  = 8'h00;
    bus.err_clr   = 1'b0;
    modelReset();
    #12;
    checkOutput("rstBitslip", 16'(bus.bitslip), 16'd0);
    checkOutput("rstLocked", 16'(bus.locked), 16'd0);
    checkOutput("rstDecValid", 16'(bus.dec_valid), 16'd0);
    checkOutput("rstDecWord", 16'(bus.dec_word), 16'd0);
    checkOutput("rstErr", bus.err_count, 16'd0);
    doReset();

    $display("[TB] all-zero stream: periodic bitslip");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 8'h00, 1'b0);
      checkOutput("slipPattern", 16'(bus.bitslip), 16'((i % (SLIP_WAIT + 1)) == 0));
    end
    doReset();

    $display("[TB] lock acquisition and vector table");
    acquireLock();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].valid, vecs[i].word, vecs[i].clr);
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d.locked", i), 16'(bus.locked), 16'(vecs[i].expLocked));
      checkOutput($sformatf("vec%0d.decValid", i), 16'(bus.dec_valid), 16'(vecs[i].expDecValid));
      checkOutput($sformatf("vec%0d.isK", i), 16'(bus.dec_isK), 16'(vecs[i].expIsK));
      checkOutput($sformatf("vec%0d.err", i), bus.err_count, 16'(vecs[i].expErr));
    end

    $display("[TB] reset while locked");
    doReset();
    acquireLock();
    applyStimulus(1'b1, 8'hFF, 1'b0);
    applyStimulus(1'b1, 8'hFF, 1'b0);
    applyStimulus(1'b1, 8'hFF, 1'b0);
    applyStimulus(1'b1, 8'h78, 1'b0);
    applyStimulus(1'b1, 8'hFF, 1'b0);
    applyStimulus(1'b1, 8'hFF, 1'b0);
    @(posedge clk); #1;
    checkOutput("preRstErr", bus.err_count, 16'd5);
    checkOutput("preRstLocked", 16'(bus.locked), 16'd1);
    bus.raw_valid = 1'b1;
    bus.raw_word  = 8'hFF;
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncLocked", 16'(bus.locked), 16'd0);
    checkOutput("asyncErr", bus.err_count, 16'd0);
    checkOutput("asyncBitslip", 16'(bus.bitslip), 16'd0);
    checkOutput("asyncDecValid", 16'(bus.dec_valid), 16'd0);
    doReset();
    acquireLock();

    $display("[TB] randomized stream against model");
    doReset();
    foreach (pct[p]) begin
      for (int n = 0; n < 600; n++) begin
        applyStimulus($urandom_range(0, 9) < 8, pickWord(pct[p]), $urandom_range(0, 63) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
